crg_seg_sub: RTL and testbench

- Limb-serial segmented subtractor for the correlated random generator datapath.
- Computes `res = a - b` per element over a 256-bit word (prng_t), one 32-bit limb per cycle.
- Element width is 32/64/128/256 per width_t. The borrow chain is cut at element boundaries using the shared carry mask.
- It is the subtract-side counterpart of the segmented adder. It is used to derive masked shares (e.g. `e = x - a`) from PRNG words.

---
 rtl/crg_seg_sub_pkg.sv | 54 +++++
 rtl/crg_limb_addsub.sv | 21 ++
 rtl/crg_seg_sub.sv | 115 +++++++++++
 tb/tb_crg_seg_sub.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/crg_seg_sub_pkg.sv
// Shared types and helpers for the limb-serial segmented add/sub datapath.
package crg_seg_sub_pkg;

  localparam int LEN_PRNG = 256;
  localparam int LIMB_W   = 32;
  localparam int N_LIMB   = LEN_PRNG / 32;

  typedef logic [LEN_PRNG-1:0] prng_t;
  typedef logic [2:0]          width_t;

  // Legal element widths; each set bit merges one level of neighbouring limbs.
  localparam width_t W_32  = 3'b000;
  localparam width_t W_64  = 3'b100;
  localparam width_t W_128 = 3'b110;
  localparam width_t W_256 = 3'b111;

  typedef struct packed {
    logic              c;
    logic [LIMB_W-1:0] w;
  } u32_w_c_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seg_sub_state_t;

  // Bit i set means the carry into bit i is cut (an element starts there).
  // width[2] joins 32-bit pairs, width[1] joins 64-bit pairs, width[0]
  // joins 128-bit pairs. Illegal encodings are applied bit by bit.
  function automatic prng_t make_carry_mask(input width_t w);
    prng_t m;
    m    = '0;
    m[0] = 1'b1;
    for (int k = 1; k < N_LIMB; k++) begin
      if (k % 2 == 1)      m[LIMB_W*k] = ~w[2];
      else if (k % 4 == 2) m[LIMB_W*k] = ~w[1];
      else                 m[LIMB_W*k] = ~w[0];
    end
    return m;
  endfunction

  // Per-limb element start flags taken from the carry mask.
  function automatic logic [N_LIMB-1:0] elem_start(input width_t w);
    prng_t             m;
    logic [N_LIMB-1:0] s;
    m    = make_carry_mask(w);
    s    = '0;
    s[0] = 1'b1;
    for (int k = 1; k < N_LIMB; k++) s[k] = m[LIMB_W*k];
    return s;
  endfunction

endpackage

// File: rtl/crg_limb_addsub.sv
// One 32-bit limb of add or subtract with carry in/out (op=1 adds).
module crg_limb_addsub
  import crg_seg_sub_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  input  logic              op,
  output u32_w_c_t          res
);

  logic [LIMB_W:0] sum;

  // Subtract is a + ~b + 1 at element start; carry out high means no borrow.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, (op ? b : ~b)} + {{LIMB_W{1'b0}}, cin};
    res.c = sum[LIMB_W];
    res.w = sum[LIMB_W-1:0];
  end

endmodule

// File: rtl/crg_seg_sub.sv
// Limb-serial segmented subtractor: res = a - b per element, one limb/cycle.
// Optional CRG_SEG_SUB_ADD_EN adds op_add_i, turning the block into an adder.
module crg_seg_sub
  import crg_seg_sub_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  prng_t             a_i,
  input  prng_t             b_i,
  input  width_t            width_i,
`ifdef CRG_SEG_SUB_ADD_EN
  input  logic              op_add_i,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output prng_t             res_o,
  output logic [N_LIMB-1:0] borrow_o
);

  localparam int LIMBS = N_LIMB;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state;
  logic [2:0]       k;
  prng_t            a_q;
  prng_t            b_q;
  width_t           width_q;
  logic             carry_q;
  prng_t            res_q;
  logic [LIMBS-1:0] borrow_q;
  logic             op_q;

`ifndef CRG_SEG_SUB_ADD_EN
  assign op_q = 1'b0;
`endif

  logic [LIMBS-1:0] start;
  logic [LIMBS-1:0] top;
  logic [7:0]       idx;
  logic             cin;
  u32_w_c_t         lr;

  // Element start/top flags and carry-in selection for the current limb.
  always_comb begin
    start = elem_start(width_q);
    top   = {1'b1, start[LIMBS-1:1]};
    idx   = {k, 5'b0};
    cin   = start[k] ? ~op_q : carry_q;
  end

  crg_limb_addsub u_limb (
    .a   (a_q[idx +: LIMB_W]),
    .b   (b_q[idx +: LIMB_W]),
    .cin (cin),
    .op  (op_q),
    .res (lr)
  );

  // Control FSM plus operand capture and limb-by-limb result writeback.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      k        <= '0;
      a_q      <= '0;
      b_q      <= '0;
      width_q  <= '0;
      carry_q  <= 1'b0;
      res_q    <= '0;
      borrow_q <= '0;
`ifdef CRG_SEG_SUB_ADD_EN
      op_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            width_q  <= width_i;
`ifdef CRG_SEG_SUB_ADD_EN
            op_q     <= op_add_i;
`endif
            res_q    <= '0;
            borrow_q <= '0;
            k        <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q[idx +: LIMB_W] <= lr.w;
          // Add reports carry, subtract reports borrow (inverted carry).
          borrow_q[k] <= top[k] & (op_q ? lr.c : ~lr.c);
          carry_q     <= lr.c;
          k           <= k + 3'd1;
          if (k == 3'd7) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state == ST_IDLE);
  assign out_valid_o = (state == ST_DONE);
  assign res_o       = res_q;
  assign borrow_o    = borrow_q;

endmodule

// File: tb/tb_crg_seg_sub.sv
// Self-checking bench for crg_seg_sub: directed plan cases plus random words
// compared with a whole-element arithmetic reference model.
module tb_crg_seg_sub;
  import crg_seg_sub_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  prng_t       a = '0, b = '0;
  width_t      w = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  prng_t       res;
  logic [7:0]  borrow;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  crg_seg_sub dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .width_i     (w),
`ifdef CRG_SEG_SUB_ADD_EN
    .op_add_i    (1'b0),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res),
    .borrow_o    (borrow)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: each element is one big unsigned number; subtract modulo
  // 2^elem_bits and flag a borrow at the element's top limb when a < b.
  function automatic void model(input prng_t ma, input prng_t mb, input width_t mw,
                                output prng_t r, output logic [7:0] br);
    int n;
    logic [256:0] av, bv, d, mask;
    case (mw)
      W_32:    n = 1;
      W_64:    n = 2;
      W_128:   n = 4;
      default: n = 8;
    endcase
    r = '0;
    br = '0;
    mask = (257'd1 << (32 * n)) - 257'd1;
    for (int e = 0; e < 8; e += n) begin
      av = ({1'b0, ma} >> (32 * e)) & mask;
      bv = ({1'b0, mb} >> (32 * e)) & mask;
      d  = (av - bv) & mask;
      for (int j = 0; j < n; j++) r[(e + j) * 32 +: 32] = d[j * 32 +: 32];
      br[e + n - 1] = (av < bv);
    end
  endfunction

  function automatic prng_t rnd256();
    prng_t v;
    for (int i = 0; i < 8; i++) v[i * 32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_op(input prng_t ta, input prng_t tb, input width_t tw);
    @(negedge clk);
    chk("in_ready_idle", {255'b0, in_ready}, 256'd1);
    a = ta; b = tb; w = tw;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, scrambling operand inputs to show they are ignored.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      a = rnd256(); b = rnd256(); w = 3'($urandom);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input prng_t ta, input prng_t tb, input width_t tw,
                              input string tag, output prng_t r, output logic [7:0] br);
    model(ta, tb, tw, r, br);
    chk({tag, "_res"}, res, r);
    chk({tag, "_borrow"}, {248'b0, borrow}, {248'b0, br});
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_op(input prng_t ta, input prng_t tb, input width_t tw,
                       input string tag, output prng_t r, output logic [7:0] br);
    int cyc;
    start_op(ta, tb, tw);
    wait_done(cyc);
    chk({tag, "_latency"}, 256'(cyc), 256'd8);
    check_result(ta, tb, tw, tag, r, br);
    pop();
  endtask

  initial begin
    prng_t      r, ta, tb, a2, b2, ones;
    logic [7:0] br;
    int         cyc;
    width_t     wtab [4];
    wtab[0] = W_32; wtab[1] = W_64; wtab[2] = W_128; wtab[3] = W_256;
    ones = '1;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {255'b0, in_ready}, 256'd1);
    chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
    chk("rst_res", res, 256'd0);
    chk("rst_borrow", {248'b0, borrow}, 256'd0);

    // 32-bit: 0 - 1 in every limb
    tb = '0;
    for (int i = 0; i < 8; i++) tb[i * 32 +: 32] = 32'd1;
    do_op('0, tb, W_32, "w32", r, br);
    chk("w32_const_res", res, ones);
    chk("w32_const_borrow", {248'b0, borrow}, 256'hFF);

    // 256-bit: 0 - 1
    do_op('0, 256'd1, W_256, "w256", r, br);
    chk("w256_const_res", res, ones);
    chk("w256_const_borrow", {248'b0, borrow}, 256'h80);

    // 64-bit: 0 - 1 per element
    tb = '0;
    for (int i = 0; i < 4; i++) tb[i * 64 +: 64] = 64'd1;
    do_op('0, tb, W_64, "w64", r, br);
    chk("w64_const_res", res, ones);
    chk("w64_const_borrow", {248'b0, borrow}, 256'hAA);

    // 128-bit: 2^64 - 1 per element, then 0 - 1
    ta = '0; tb = '0;
    for (int i = 0; i < 2; i++) begin
      ta[i * 128 + 64] = 1'b1;
      tb[i * 128] = 1'b1;
    end
    do_op(ta, tb, W_128, "w128a", r, br);
    chk("w128a_const_res", res,
        {64'd0, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 64'hFFFFFFFF_FFFFFFFF});
    chk("w128a_const_borrow", {248'b0, borrow}, 256'h00);
    do_op('0, tb, W_128, "w128b", r, br);
    chk("w128b_const_borrow", {248'b0, borrow}, 256'h88);

    // Backpressure: hold result for 5 cycles, then overlap in_valid with pop
    ta = rnd256(); tb = rnd256();
    start_op(ta, tb, W_64);
    wait_done(cyc);
    chk("bp_latency", 256'(cyc), 256'd8);
    model(ta, tb, W_64, r, br);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_res", res, r);
      chk("bp_hold_borrow", {248'b0, borrow}, {248'b0, br});
      chk("bp_hold_in_ready", {255'b0, in_ready}, 256'd0);
      chk("bp_hold_out_valid", {255'b0, out_valid}, 256'd1);
    end
    a2 = rnd256(); b2 = rnd256();
    a = a2; b = b2; w = W_32;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_pop_out_valid", {255'b0, out_valid}, 256'd0);
    chk("bp_pop_in_ready", {255'b0, in_ready}, 256'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept_in_ready", {255'b0, in_ready}, 256'd0);
    wait_done(cyc);
    chk("bp2_latency", 256'(cyc), 256'd8);
    check_result(a2, b2, W_32, "bp2", r, br);
    pop();

    // Reset in the middle of RUN (limb 3 pending)
    start_op(rnd256(), rnd256(), W_256);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", {255'b0, out_valid}, 256'd0);
    chk("mrst_res", res, 256'd0);
    chk("mrst_borrow", {248'b0, borrow}, 256'd0);
    chk("mrst_in_ready", {255'b0, in_ready}, 256'd1);
    rst = 1'b0;
    cyc = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cyc++;
    end
    chk("mrst_no_spurious", 256'(cyc), 256'd0);
    chk("mrst_idle_ready", {255'b0, in_ready}, 256'd1);

    // Random words across all legal widths
    for (int t = 0; t < 24; t++) begin
      ta = rnd256();
      case ($urandom_range(0, 3))
        0: tb = ta;
        1: tb = ta ^ (256'd1 << $urandom_range(0, 255));
        default: tb = rnd256();
      endcase
      do_op(ta, tb, wtab[$urandom_range(0, 3)], $sformatf("rnd%0d", t), r, br);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
